// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS datapath blocks.
//
// Contents used by seq_mult_16bit:
//   MUL_IDLE / MUL_CALC / MUL_DONE  multiplier FSM state encodings (2 bits)
//   MUL_ITER                        number of shift-and-add iterations
//   MUL_CNT_LAST                    value of the 4-bit iteration counter on
//                                   the final iteration
//   mul_step()                      one shift-and-add step of the accumulator
package mips_pkg;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_CALC = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

  localparam int MUL_ITER = 16;

  localparam logic [3:0] MUL_CNT_LAST = 4'(MUL_ITER - 1);

  // One iteration of the accumulator update. When the multiplier bit in
  // acc[0] is set, the adder result (with its carry-out as the new top bit)
  // replaces the high half before the shift; otherwise the accumulator is
  // simply shifted right by one. Keeping the carry in bit 31 is what lets
  // 0xFFFF * 0xFFFF fit in 32 bits.
  function automatic logic [31:0] mul_step(
    input logic [31:0] acc,
    input logic [15:0] sum,
    input logic        c_out
  );
    logic [31:0] result;
    if (acc[0]) begin
      result = {c_out, sum, acc[15:1]};
    end else begin
      result = {1'b0, acc[31:16], acc[15:1]};
    end
    return result;
  endfunction

endpackage

// File: rtl/cla_16bit.sv
// cla_16bit: 16-bit two-level carry-lookahead adder.
//
// Ports:
//   a, b   in  16  addends
//   c_in   in  1   carry into bit 0
//   sum    out 16  a + b + c_in (low 16 bits)
//   c_out  out 1   carry out of bit 15
//
// Four 4-bit groups each produce a group generate/propagate pair. The group
// carry-ins are computed in one flat lookahead level from those pairs, and
// each group then expands its own internal carries from its group carry-in.
// Internal carries depend only on the group carry-in vector, never on each
// other, so there is no ripple path inside the adder.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] carry;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;

      assign carry[B]   = cg[gi];
      assign carry[B+1] = g[B] | (p[B] & cg[gi]);
      assign carry[B+2] = g[B+1]
                        | (p[B+1] & g[B])
                        | (p[B+1] & p[B] & cg[gi]);
      assign carry[B+3] = g[B+2]
                        | (p[B+2] & g[B+1])
                        | (p[B+2] & p[B+1] & g[B])
                        | (p[B+2] & p[B+1] & p[B] & cg[gi]);

      assign gg[gi] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign pg[gi] = &p[B+3:B];
    end
  endgenerate

  // Second lookahead level: group carry-ins straight from c_in.
  assign cg[0] = c_in;
  assign cg[1] = gg[0] | (pg[0] & c_in);
  assign cg[2] = gg[1]
               | (pg[1] & gg[0])
               | (pg[1] & pg[0] & c_in);
  assign cg[3] = gg[2]
               | (pg[2] & gg[1])
               | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & c_in);
  assign cg[4] = gg[3]
               | (pg[3] & gg[2])
               | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & c_in);

  assign sum   = p ^ carry;
  assign c_out = cg[4];

endmodule

// File: rtl/seq_mult_16bit.sv
// seq_mult_16bit: multi-cycle unsigned 16x16->32 shift-and-add multiplier.
//
// Ports:
//   clk           in  1   rising-edge clock
//   reset         in  1   asynchronous active-high reset
//   start         in  1   start request, honoured only in IDLE
//   multiplicand  in  16  operand A, captured when start is accepted
//   multiplier    in  16  operand B, captured when start is accepted
//   product       out 32  registered A*B, updated only when an operation ends
//   busy          out 1   high while iterating
//   done          out 1   one-cycle pulse in the cycle product is updated
//
// Flow: IDLE -(start)-> CALC (16 iterations) -> DONE (1 cycle) -> IDLE.
// The multiplier is loaded into acc[15:0]; each iteration inspects acc[0],
// optionally adds the multiplicand into the high half via cla_16bit, and
// shifts the whole accumulator right by one. After 16 iterations the
// accumulator holds the full product. Requests arriving in CALC or DONE are
// dropped, not queued. Only WIDTH = 16 is meaningful since the adder is a
// fixed 16-bit instance.
module seq_mult_16bit
  import mips_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  logic [1:0]  state;
  logic [31:0] acc;
  logic [15:0] mcand_q;
  logic [3:0]  count;

  logic [15:0] add_sum;
  logic        add_cout;
  logic [31:0] acc_next;

  // High half of the partial product plus the multiplicand; the carry-in is
  // tied low because every step is a plain unsigned add.
  cla_16bit u_cla (
    .a     (acc[31:16]),
    .b     (mcand_q),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  assign acc_next = mul_step(acc, add_sum, add_cout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MUL_IDLE;
      acc     <= '0;
      mcand_q <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand_q <= multiplicand[15:0];
            acc     <= {16'h0000, multiplier[15:0]};
            count   <= '0;
            busy    <= 1'b1;
            state   <= MUL_CALC;
          end
        end

        MUL_CALC: begin
          acc   <= acc_next;
          count <= count + 4'd1;
          // The last iteration publishes the shifted value directly, so
          // product never sees a partial result.
          if (count == MUL_CNT_LAST) begin
            product <= acc_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= MUL_DONE;
          end
        end

        MUL_DONE: begin
          done  <= 1'b0;
          state <= MUL_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_16bit.sv
module tb_seq_mult_16bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  seq_mult_16bit #(.WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an accepted request yields a*b after 16 busy cycles,
  // followed by one done cycle; everything else is ignored.
  int          m_phase;      // 0 idle, 1 busy, 2 done
  int          m_cycles;
  logic [31:0] m_pending;
  logic [31:0] m_product;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase   = 0;
      m_cycles  = 0;
      m_pending = 32'h0;
      m_product = 32'h0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_pending = 32'(multiplicand) * 32'(multiplier);
          m_cycles  = 0;
          m_phase   = 1;
        end
      end else if (m_phase == 1) begin
        m_cycles = m_cycles + 1;
        if (m_cycles == 16) begin
          m_product = m_pending;
          m_phase   = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checks = checks + 1;
    if (busy !== (m_phase == 1) || done !== (m_phase == 2) || product !== m_product) begin
      failures = failures + 1;
      $display("FAIL cycle_model t=%0t busy=%b done=%b product=%h required busy=%b done=%b product=%h",
               $time, busy, done, product, (m_phase == 1), (m_phase == 2), m_product);
    end
  end

  task automatic check32(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; returns after the edge that accepted it (E0).
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Wait (bounded) for done; reports how many cycles busy was seen high.
  task automatic wait_done(input string name, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cycles++;
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL %s_timeout actual=no_done required=done_within_40", name);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] expected);
    int bc;
    issue(a, b);
    wait_done(name, bc);
    check32({name, "_product"}, product, expected);
    check32({name, "_busy_cycles"}, 32'(bc), 32'd16);
    tick();   // DONE -> IDLE
  endtask

  task automatic count_dones(input int cycles, output int n_done);
    n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
  endtask

  initial begin
    int nd;
    int bc;
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = 16'h0;
    multiplier   = 16'h0;
    tick();
    tick();
    check32("reset_product", product, 32'h0);
    check32("reset_busy", {31'b0, busy}, 32'h0);
    check32("reset_done", {31'b0, done}, 32'h0);
    reset = 1'b0;
    tick();

    run_op("basic_3x5", 16'd3, 16'd5, 32'h0000000F);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("zero", 16'h0000, 16'h1234, 32'h00000000);
    run_op("identity", 16'hABCD, 16'h0001, 32'h0000ABCD);

    // Request while busy must be dropped.
    issue(16'd7, 16'd9);
    repeat (5) tick();
    issue(16'd2, 16'd2);
    wait_done("busy_start", bc);
    check32("busy_start_product", product, 32'h0000003F);
    count_dones(30, nd);
    check32("busy_start_extra_done", 32'(nd), 32'd0);
    check32("busy_start_idle", {31'b0, busy}, 32'h0);

    // Reset in the middle of iterating.
    issue(16'h1234, 16'h5678);
    repeat (8) tick();
    reset = 1'b1;
    #1;
    check32("midreset_product", product, 32'h0);
    check32("midreset_busy", {31'b0, busy}, 32'h0);
    check32("midreset_done", {31'b0, done}, 32'h0);
    tick();
    reset = 1'b0;
    count_dones(25, nd);
    check32("midreset_no_done", 32'(nd), 32'd0);
    run_op("clean_1234x5678", 16'h1234, 16'h5678, 32'h06260060);

    // Back-to-back: second request on the first IDLE cycle after done.
    issue(16'd6, 16'd7);
    wait_done("b2b_first", bc);
    check32("b2b_first_product", product, 32'h0000002A);
    tick();
    issue(16'h8000, 16'h0002);
    repeat (4) tick();
    check32("b2b_hold_busy", {31'b0, busy}, 32'h1);
    check32("b2b_hold_product", product, 32'h0000002A);
    wait_done("b2b_second", bc);
    check32("b2b_second_product", product, 32'h00010000);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
